// File: rtl/alu_defs.sv
// rtl/alu_defs.sv - ALUCode constants and the shared code width default
package alu_defs;

  // Default width of the ALUCode field
  localparam int CODE_W_DEF = 5;

  // ALUCode values understood by the shared ALU; all other codes yield zero
  typedef enum logic [CODE_W_DEF-1:0] {
    ALU_ADD  = 5'd0,
    ALU_AND  = 5'd1,
    ALU_XOR  = 5'd2,
    ALU_OR   = 5'd3,
    ALU_NOR  = 5'd4,
    ALU_SUB  = 5'd5,
    ALU_ANDI = 5'd6,
    ALU_XORI = 5'd7,
    ALU_ORI  = 5'd8,
    ALU_SLL  = 5'd16,
    ALU_SRL  = 5'd17,
    ALU_SRA  = 5'd18,
    ALU_SLT  = 5'd19,
    ALU_SLTU = 5'd20
  } alu_code_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// rtl/alu_arbiter_alu.sv - combinational ALU shared by the two requesters
module alu_arbiter_alu
  import alu_defs::*;
#(
  parameter int DATA_W = 32,
  parameter int CODE_W = CODE_W_DEF
) (
  input  logic [CODE_W-1:0] code,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              overflow
);

  localparam int SH_W = $clog2(DATA_W);
  localparam int MSB  = DATA_W - 1;

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic [DATA_W-1:0] imm_b;
  logic [SH_W-1:0]   shamt;
  logic              add_ovf;
  logic              sub_ovf;

  assign sum   = a + b;
  assign diff  = a - b;
  // Immediate forms use only the low half of B, zero-extended
  assign imm_b = {{(DATA_W-16){1'b0}}, b[15:0]};
  assign shamt = b[SH_W-1:0];

  // Signed overflow: same-sign operands giving a different-sign sum, and the
  // subtract equivalent with B's sign inverted
  assign add_ovf = (a[MSB] == b[MSB]) & (sum[MSB] != a[MSB]);
  assign sub_ovf = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]);

  // Raw overflow is reported for every code; the arbiter masks it to add/sub
  always_comb begin
    overflow = (code == CODE_W'(ALU_SUB)) ? sub_ovf : add_ovf;
  end

  // Result select by ALUCode; undefined codes produce zero
  always_comb begin
    result = '0;
    case (code)
      CODE_W'(ALU_ADD):  result = sum;
      CODE_W'(ALU_AND):  result = a & b;
      CODE_W'(ALU_XOR):  result = a ^ b;
      CODE_W'(ALU_OR):   result = a | b;
      CODE_W'(ALU_NOR):  result = ~(a | b);
      CODE_W'(ALU_SUB):  result = diff;
      CODE_W'(ALU_ANDI): result = a & imm_b;
      CODE_W'(ALU_XORI): result = a ^ imm_b;
      CODE_W'(ALU_ORI):  result = a | imm_b;
      CODE_W'(ALU_SLL):  result = a << shamt;
      CODE_W'(ALU_SRL):  result = a >> shamt;
      CODE_W'(ALU_SRA):  result = $unsigned($signed(a) >>> shamt);
      CODE_W'(ALU_SLT):  result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      CODE_W'(ALU_SLTU): result = {{(DATA_W-1){1'b0}}, (a < b)};
      default:           result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin two-port arbiter in front of one ALU, registered response (ALU_ARB_FIXED_PRIO_EN selects fixed priority)
module alu_arbiter
  import alu_defs::*;
#(
  parameter int DATA_W = 32,
  parameter int CODE_W = CODE_W_DEF,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CODE_W-1:0] req0_code,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [TAG_W-1:0]  req0_tag,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CODE_W-1:0] req1_code,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [TAG_W-1:0]  req1_tag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_overflow,
  output logic              rsp_src,
  output logic [TAG_W-1:0]  rsp_tag
);

  logic              last_grant;
  logic              can_accept;
  logic              grant_any;
  logic              grant_sel;
  logic              accept;
  logic [CODE_W-1:0] sel_code;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [TAG_W-1:0]  sel_tag;
  logic [DATA_W-1:0] alu_result;
  logic              alu_overflow;
  logic              ovf_masked;

  // The response slot is free when empty or being drained this cycle
  assign can_accept = ~rsp_valid | rsp_ready;

  // Grant choice: a lone requester wins; on a tie the one not served last wins
  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_sel = 1'b0;
    if (req0_valid & req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      grant_sel = 1'b0;
`else
      grant_sel = ~last_grant;
`endif
    end else begin
      grant_sel = req1_valid;
    end
  end

  // Ready is only offered out of reset and when the response slot can load
  assign req0_ready = ~reset & can_accept & grant_any & ~grant_sel;
  assign req1_ready = ~reset & can_accept & grant_any &  grant_sel;
  assign accept     = req0_ready | req1_ready;

  // Route the granted operation to the shared ALU
  always_comb begin
    sel_code = grant_sel ? req1_code : req0_code;
    sel_a    = grant_sel ? req1_a    : req0_a;
    sel_b    = grant_sel ? req1_b    : req0_b;
    sel_tag  = grant_sel ? req1_tag  : req0_tag;
  end

  alu_arbiter_alu #(
    .DATA_W (DATA_W),
    .CODE_W (CODE_W)
  ) u_alu (
    .code     (sel_code),
    .a        (sel_a),
    .b        (sel_b),
    .result   (alu_result),
    .overflow (alu_overflow)
  );

  // Overflow is meaningful only for add and sub
  always_comb begin
    ovf_masked = alu_overflow &
                 ((sel_code == CODE_W'(ALU_ADD)) | (sel_code == CODE_W'(ALU_SUB)));
  end

  // Response register and priority pointer; priority moves only on accept
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
      rsp_src      <= 1'b0;
      rsp_tag      <= '0;
      last_grant   <= 1'b1;
    end else if (accept) begin
      rsp_valid    <= 1'b1;
      rsp_result   <= alu_result;
      rsp_overflow <= ovf_masked;
      rsp_src      <= grant_sel;
      rsp_tag      <= sel_tag;
      last_grant   <= grant_sel;
    end else if (rsp_ready) begin
      rsp_valid    <= 1'b0;
    end
  end

endmodule
